// File: rtl/stage_fifo.sv
// First-word-fall-through FIFO linking two pipeline stages.
// Status flags come only from registered pointers; overflow/underflow are sticky.
module stage_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);

  // The extra MSB separates the full case from the empty case.
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data     = mem[rd_ptr[AW-1:0]];
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_CNT);

endmodule

// File: tb/tb_stage_fifo.sv
// Scoreboard bench for stage_fifo (DEPTH=4, AF_LEVEL=3): directed scenarios,
// then random wr_en/rd_en traffic checked against a reference queue.
module tb_stage_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty, full, almost_full, overflow, underflow;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_q [$];
  logic [DW-1:0] exp_q [$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  stage_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every accepted read at the coming edge must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%0h, expected no read at %0t", rd_data, $time);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_flags(input string tag);
    int n;
    n = ref_q.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  // One clock cycle of traffic; the reference model decides acceptance from its own state.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input bit chk);
    bit acc_w, acc_r, was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r;
    was_full  = (ref_q.size() == DEPTH);
    was_empty = (ref_q.size() == 0);
    acc_w = w && !was_full;
    acc_r = r && !was_empty;
    if (acc_r) exp_q.push_back(ref_q[0]);
    @(posedge clk); #1;
    if (acc_r) void'(ref_q.pop_front());
    if (acc_w) ref_q.push_back(d);
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (chk) check_flags("step");
  endtask

  task automatic reset_with(input logic w, input logic [DW-1:0] d);
    rst = 1'b1; wr_en = w; wr_data = d; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    ref_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    reset_with(1'b0, '0);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.count", 32'(count), 32'd0);
    check_flags("reset");

    // Single word through an empty queue.
    step(1'b1, 32'hA1, 1'b0, 1'b1);
    check("fwft.rd_data", rd_data, 32'hA1);
    check("fwft.count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("drain.empty", 32'(empty), 32'd1);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b1);
      if (i == 3) check("af_after3", 32'(almost_full), 32'd1);
    end
    check("full_after4", 32'(full), 32'd1);
    check("count_after4", 32'(count), 32'd4);
    step(1'b1, 32'h5, 1'b0, 1'b1);
    check("ovf.count", 32'(count), 32'd4);
    check("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1);

    // Simultaneous streaming at count=2 wraps the pointers several times.
    reset_with(1'b0, '0);
    step(1'b1, 32'h10, 1'b0, 1'b1);
    step(1'b1, 32'h11, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h12 + DW'(i), 1'b1, 1'b1);
      check("stream.count", 32'(count), 32'd2);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Full blocks the write even with a concurrent read.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + DW'(i), 1'b0, 1'b1);
    step(1'b1, 32'h24, 1'b1, 1'b1);
    check("full_rw.count", 32'(count), 32'd3);
    check("full_rw.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);

    // Empty blocks the read but the write lands.
    reset_with(1'b0, '0);
    step(1'b1, 32'hBEEF, 1'b1, 1'b1);
    check("empty_rw.udf", 32'(underflow), 32'd1);
    check("empty_rw.count", 32'(count), 32'd1);
    check("empty_rw.rd_data", rd_data, 32'hBEEF);

    // Reset with a write pending discards everything.
    step(1'b1, 32'h31, 1'b0, 1'b1);
    step(1'b1, 32'h32, 1'b0, 1'b1);
    check("pre_rst.count", 32'(count), 32'd3);
    reset_with(1'b1, 32'h33);
    check("rst_wr.empty", 32'(empty), 32'd1);
    check("rst_wr.count", 32'(count), 32'd0);
    check("rst_wr.ovf", 32'(overflow), 32'd0);
    check("rst_wr.udf", 32'(underflow), 32'd0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
    while (ref_q.size() > 0) step(1'b0, '0, 1'b1, 1'b1);

    @(negedge clk);
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_fifo.md
STAGE_FIFO -- requirements
Module: stage_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each stored word.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 wr_en  input  1  producer write request; the upstream stage's write_fifo.
REQ-007 wr_data  input  DATA_WIDTH  word to write.
REQ-008 rd_en  input  1  consumer read/pop request; the downstream stage's read_fifo.
REQ-009 rd_data  output  DATA_WIDTH  head-of-queue word; first-word-fall-through.
REQ-010 empty  output  1  queue holds no entries; drives the consumer's inputs_empty bit.
REQ-011 full  output  1  queue holds DEPTH entries; drives the producer's outputs_full bit.
REQ-012 almost_full  output  1  count >= AF_LEVEL.
REQ-013 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky: a write was attempted while full.
REQ-015 underflow  output  1  sticky: a read was attempted while empty.

Function
REQ-016 Accepted write = wr_en && !full, sampled at the clock edge; the word is stored at the tail and the tail pointer advances by 1.
REQ-017 Accepted read = rd_en && !empty; the head pointer advances by 1.
REQ-018 full SHALL block a write even if an accepted read occurs in the same cycle; the write is dropped and overflow sets.
REQ-019 empty SHALL block a read even if a write occurs in the same cycle; the read is ignored, underflow sets, and the write is still accepted.
REQ-020 An accepted read and an accepted write in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-021 Pointers are clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; the low bits index storage. full = pointers differ only in the MSB; empty = pointers equal.
REQ-022 count, empty, full, and almost_full are registered or derived from registered pointers only, never from same-cycle wr_en or rd_en.
REQ-023 rd_data SHALL equal storage[head] whenever empty=0, with no read latency (FWFT); its value while empty=1 is don't-care.
REQ-024 A word written into an empty queue SHALL appear on rd_data, with empty deasserted, in the cycle after the write edge.
REQ-025 After an accepted read, rd_data SHALL present the next entry in the following cycle, or empty SHALL assert if none remains.
REQ-026 Data order is strict FIFO; no entry is lost, duplicated, or reordered across pointer wrap-around.
REQ-027 overflow and underflow, once set, hold until reset; the overflow or underflow attempt changes no other state.

Reset
REQ-028 On a rising clk with rst=1: pointers=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-029 Storage contents are not cleared; rd_data is don't-care after reset until the first write.
REQ-030 rst takes priority over wr_en and rd_en in the same cycle; a write presented with rst is discarded.
REQ-031 Reset mid-operation with a partially full queue SHALL discard all entries; empty=1 in the first cycle after the reset edge.

Verification (DEPTH=4, AF_LEVEL=3, DATA_WIDTH=32)
REQ-032 Reset, then write 0xA1 for one cycle -> the next cycle shows empty=0, count=1, rd_data=0xA1; one read leaves empty=1, count=0.
REQ-033 Write 0x1, 0x2, 0x3, 0x4 back-to-back -> almost_full=1 after the 3rd write, full=1 and count=4 after the 4th; a 5th write of 0x5 leaves count=4 and sets overflow=1; reads return 1, 2, 3, 4.
REQ-034 Run a 10-cycle stream with wr_en=rd_en=1 starting from count=2 -> count stays 2, output order matches input order, and the pointers wrap at least twice without error.
REQ-035 With full=1, assert wr_en and rd_en together -> the read is accepted, the write is dropped, count=3, overflow=1.
REQ-036 With empty=1, assert wr_en (0xBEEF) and rd_en together -> underflow=1, the next cycle shows count=1 and rd_data=0xBEEF.
REQ-037 With count=3, assert rst together with wr_en -> the next cycle shows empty=1, count=0, and overflow=underflow=0.
REQ-038 A scoreboard SHALL compare every accepted read against a reference queue under random wr_en/rd_en traffic for at least 10k cycles.
